// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, OCLASS bit positions, immediate formats
// and the immediate generator.
package decode_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BCC   = 7'b1100011;
    localparam logic [6:0] OP_LCC   = 7'b0000011;
    localparam logic [6:0] OP_SCC   = 7'b0100011;
    localparam logic [6:0] OP_MCC   = 7'b0010011;
    localparam logic [6:0] OP_RCC   = 7'b0110011;
    localparam logic [6:0] OP_CUS   = 7'b0001011;
    localparam logic [6:0] OP_CCC   = 7'b1110011;

    localparam int CLS_LUI   = 0;
    localparam int CLS_AUIPC = 1;
    localparam int CLS_JAL   = 2;
    localparam int CLS_JALR  = 3;
    localparam int CLS_BCC   = 4;
    localparam int CLS_LCC   = 5;
    localparam int CLS_SCC   = 6;
    localparam int CLS_MCC   = 7;
    localparam int CLS_RCC   = 8;
    localparam int CLS_CUS   = 9;
    localparam int CLS_CCC   = 10;
    localparam int NCLASS    = 11;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    function automatic logic [31:0] imm_gen(input imm_fmt_e fmt, input logic [31:0] ins);
        logic [31:0] imm;
        imm = 32'd0;
        case (fmt)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'd0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake/payload bundle of the decode stage.
interface decode_if #(
    parameter int PCW = 32,
    parameter int RW  = 5
);
    logic           flush;
    logic           ivalid;
    logic           iready;
    logic [31:0]    idata;
    logic [PCW-1:0] ipc;
    logic           ovalid;
    logic           oready;
    logic [PCW-1:0] opc;
    logic [10:0]    oclass;
    logic           oill;
    logic [RW-1:0]  odptr;
    logic [RW-1:0]  os1ptr;
    logic [RW-1:0]  os2ptr;
    logic [2:0]     ofct3;
    logic [6:0]     ofct7;
    logic [31:0]    oimm;

    modport master (
        output flush, ivalid, idata, ipc, oready,
        input  iready, ovalid, opc, oclass, oill, odptr, os1ptr, os2ptr, ofct3, ofct7, oimm
    );

    modport slave (
        input  flush, ivalid, idata, ipc, oready,
        output iready, ovalid, opc, oclass, oill, odptr, os1ptr, os2ptr, ofct3, ofct7, oimm
    );
endinterface

// File: rtl/decode_core.sv
// Combinational RV32I/E field, class, legality and immediate decode of one instruction word.
module decode_core
    import decode_pkg::*;
#(
    parameter int RW    = 5,
    parameter int RV32E = 0
) (
    input  logic [31:0]       idata,
    output logic [NCLASS-1:0] cls,
    output logic              ill,
    output logic [RW-1:0]     dptr,
    output logic [RW-1:0]     s1ptr,
    output logic [RW-1:0]     s2ptr,
    output logic [2:0]        fct3,
    output logic [6:0]        fct7,
    output logic [31:0]       imm
);
    logic [NCLASS-1:0] cls_raw_s;
    logic              use_rd_s;
    logic              use_rs1_s;
    logic              use_rs2_s;
    logic              rv32e_bad_s;
    logic [4:0]        rd_s;
    logic [4:0]        rs1_s;
    logic [4:0]        rs2_s;
    imm_fmt_e          fmt_s;

    assign rd_s  = idata[11:7];
    assign rs1_s = idata[19:15];
    assign rs2_s = idata[24:20];

    // opcode match to raw one-hot class
    always_comb begin
        cls_raw_s = {NCLASS{1'b0}};
        case (idata[6:0])
            OP_LUI:   cls_raw_s[CLS_LUI]   = 1'b1;
            OP_AUIPC: cls_raw_s[CLS_AUIPC] = 1'b1;
            OP_JAL:   cls_raw_s[CLS_JAL]   = 1'b1;
            OP_JALR:  cls_raw_s[CLS_JALR]  = 1'b1;
            OP_BCC:   cls_raw_s[CLS_BCC]   = 1'b1;
            OP_LCC:   cls_raw_s[CLS_LCC]   = 1'b1;
            OP_SCC:   cls_raw_s[CLS_SCC]   = 1'b1;
            OP_MCC:   cls_raw_s[CLS_MCC]   = 1'b1;
            OP_RCC:   cls_raw_s[CLS_RCC]   = 1'b1;
            OP_CUS:   cls_raw_s[CLS_CUS]   = 1'b1;
            OP_CCC:   cls_raw_s[CLS_CCC]   = 1'b1;
            default:  cls_raw_s = {NCLASS{1'b0}};
        endcase
    end

    // legality: CSR immediate forms reuse the rs1 field as data, so it is not a register there
    always_comb begin
        use_rd_s  = cls_raw_s[CLS_LUI] | cls_raw_s[CLS_AUIPC] | cls_raw_s[CLS_JAL] |
                    cls_raw_s[CLS_JALR] | cls_raw_s[CLS_LCC] | cls_raw_s[CLS_MCC] |
                    cls_raw_s[CLS_RCC] | cls_raw_s[CLS_CUS] | cls_raw_s[CLS_CCC];
        use_rs1_s = cls_raw_s[CLS_JALR] | cls_raw_s[CLS_BCC] | cls_raw_s[CLS_LCC] |
                    cls_raw_s[CLS_SCC] | cls_raw_s[CLS_MCC] | cls_raw_s[CLS_RCC] |
                    cls_raw_s[CLS_CUS] | (cls_raw_s[CLS_CCC] & ~idata[14]);
        use_rs2_s = cls_raw_s[CLS_BCC] | cls_raw_s[CLS_SCC] | cls_raw_s[CLS_RCC] |
                    cls_raw_s[CLS_CUS];
        rv32e_bad_s = (RV32E != 0) &&
                      ((use_rd_s && rd_s[4]) || (use_rs1_s && rs1_s[4]) || (use_rs2_s && rs2_s[4]));
        ill = (cls_raw_s == {NCLASS{1'b0}}) || (idata[1:0] != 2'b11) || rv32e_bad_s;
        cls = ill ? {NCLASS{1'b0}} : cls_raw_s;
    end

    // immediate format select and field outputs
    always_comb begin
        if (cls[CLS_JALR] || cls[CLS_LCC] || cls[CLS_MCC]) begin
            fmt_s = IMM_I;
        end else if (cls[CLS_SCC]) begin
            fmt_s = IMM_S;
        end else if (cls[CLS_BCC]) begin
            fmt_s = IMM_B;
        end else if (cls[CLS_LUI] || cls[CLS_AUIPC]) begin
            fmt_s = IMM_U;
        end else if (cls[CLS_JAL]) begin
            fmt_s = IMM_J;
        end else begin
            fmt_s = IMM_NONE;
        end
        imm   = imm_gen(fmt_s, idata);
        dptr  = (ill || cls_raw_s[CLS_BCC] || cls_raw_s[CLS_SCC]) ? {RW{1'b0}} : rd_s[RW-1:0];
        s1ptr = rs1_s[RW-1:0];
        s2ptr = rs2_s[RW-1:0];
        fct3  = idata[14:12];
        fct7  = idata[31:25];
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: decode_core ahead of a valid/ready output register.
// Optional one-entry skid buffer with registered IREADY when DECODE_SKID_EN is defined.
module decode_stage
    import decode_pkg::*;
#(
    parameter int PCW   = 32,
    parameter int RV32E = 0
) (
    input  logic    clk,
    input  logic    resn,
    decode_if.slave bus
);
    localparam int RW = (RV32E != 0) ? 4 : 5;

    typedef struct packed {
        logic [PCW-1:0]    pc;
        logic [NCLASS-1:0] cls;
        logic              ill;
        logic [RW-1:0]     dptr;
        logic [RW-1:0]     s1ptr;
        logic [RW-1:0]     s2ptr;
        logic [2:0]        fct3;
        logic [6:0]        fct7;
        logic [31:0]       imm;
    } payload_t;

    logic [NCLASS-1:0] cls_s;
    logic              ill_s;
    logic [RW-1:0]     dptr_s;
    logic [RW-1:0]     s1ptr_s;
    logic [RW-1:0]     s2ptr_s;
    logic [2:0]        fct3_s;
    logic [6:0]        fct7_s;
    logic [31:0]       imm_s;
    payload_t          dec_s;
    payload_t          out_r;
    logic              ovalid_r;
    logic              iready_s;
    logic              accept_s;

    decode_core #(
        .RW    (RW),
        .RV32E (RV32E)
    ) u_core (
        .idata (bus.idata),
        .cls   (cls_s),
        .ill   (ill_s),
        .dptr  (dptr_s),
        .s1ptr (s1ptr_s),
        .s2ptr (s2ptr_s),
        .fct3  (fct3_s),
        .fct7  (fct7_s),
        .imm   (imm_s)
    );

    // bundle the decoded fields with the instruction address
    always_comb begin
        dec_s       = '0;
        dec_s.pc    = bus.ipc;
        dec_s.cls   = cls_s;
        dec_s.ill   = ill_s;
        dec_s.dptr  = dptr_s;
        dec_s.s1ptr = s1ptr_s;
        dec_s.s2ptr = s2ptr_s;
        dec_s.fct3  = fct3_s;
        dec_s.fct7  = fct7_s;
        dec_s.imm   = imm_s;
    end

    assign accept_s = bus.ivalid && iready_s && !bus.flush;

`ifdef DECODE_SKID_EN
    payload_t skid_r;
    logic     skid_valid_r;

    assign iready_s = !skid_valid_r;

    // output register fed from the skid entry first, else straight from decode
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            ovalid_r     <= 1'b0;
            out_r        <= '0;
            skid_valid_r <= 1'b0;
            skid_r       <= '0;
        end else if (bus.flush) begin
            ovalid_r     <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (!ovalid_r || bus.oready) begin
            if (skid_valid_r) begin
                out_r        <= skid_r;
                ovalid_r     <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                out_r    <= dec_s;
                ovalid_r <= 1'b1;
            end else begin
                ovalid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_r       <= dec_s;
            skid_valid_r <= 1'b1;
        end
    end
`else
    assign iready_s = !ovalid_r || bus.oready;

    // output register: load on accept, drain on consume, payload otherwise held
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            ovalid_r <= 1'b0;
            out_r    <= '0;
        end else if (bus.flush) begin
            ovalid_r <= 1'b0;
        end else if (accept_s) begin
            out_r    <= dec_s;
            ovalid_r <= 1'b1;
        end else if (bus.oready) begin
            ovalid_r <= 1'b0;
        end
    end
`endif

    assign bus.iready = iready_s;
    assign bus.ovalid = ovalid_r;
    assign bus.opc    = out_r.pc;
    assign bus.oclass = out_r.cls;
    assign bus.oill   = out_r.ill;
    assign bus.odptr  = out_r.dptr;
    assign bus.os1ptr = out_r.s1ptr;
    assign bus.os2ptr = out_r.s2ptr;
    assign bus.ofct3  = out_r.fct3;
    assign bus.ofct7  = out_r.fct7;
    assign bus.oimm   = out_r.imm;

endmodule
